// File: rtl/rtc_transfer_sequencer.sv
// rtc_transfer_sequencer: expands one start request into per-field RTC bus cycles.
// Optional REQ watchdog is built when RTC_SEQ_TIMEOUT_EN is defined.
module rtc_transfer_sequencer #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int GAP_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_wr_time,
  input  logic        start_wr_timer,
  input  logic        start_rd_all,
  input  logic [71:0] wr_fields,
  output logic        bus_req,
  output logic        bus_rw,
  output logic [7:0]  bus_addr,
  output logic [7:0]  bus_wdata,
  input  logic [7:0]  bus_rdata,
  input  logic        bus_done,
  output logic [71:0] rd_fields,
  output logic [8:0]  field_sel,
  output logic        busy,
  output logic        done,
  output logic        err
);

  if (GAP_CYCLES < 1 || GAP_CYCLES > 15) begin : g_gap_chk
    $error("GAP_CYCLES out of range");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_tmo_chk
    $error("TIMEOUT_CYCLES must be positive");
  end

  typedef enum logic [1:0] {IDLE, REQ, GAP, FINISH} state_t;

  state_t      state_q, state_d;
  logic        go_q, go_d;
  logic        rw_q, rw_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  last_q, last_d;
  logic [3:0]  gcnt_q, gcnt_d;
  logic [71:0] snap_q, snap_d;
  logic [71:0] shadow_q, shadow_d;
  logic        req_d, rwo_d, busy_d, done_d;
  logic [7:0]  addr_d, wdata_d;
  logic [8:0]  sel_d;
  logic [71:0] rd_d;
  logic        launch;
  logic        start_any;
  logic        tmo;

  assign start_any = start_wr_time | start_wr_timer | start_rd_all;

  function automatic logic [7:0] addr_of(input logic [3:0] i);
    unique case (i)
      4'd0:    addr_of = 8'h26;
      4'd1:    addr_of = 8'h25;
      4'd2:    addr_of = 8'h24;
      4'd3:    addr_of = 8'h23;
      4'd4:    addr_of = 8'h22;
      4'd5:    addr_of = 8'h21;
      4'd6:    addr_of = 8'h43;
      4'd7:    addr_of = 8'h42;
      4'd8:    addr_of = 8'h41;
      default: addr_of = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] byte_of(
    input logic [71:0] v,
    input logic [3:0]  i
  );
    byte_of = v[{i, 3'b000} +: 8];
  endfunction

  always_comb begin
    state_d  = state_q;
    go_d     = go_q;
    rw_d     = rw_q;
    idx_d    = idx_q;
    last_d   = last_q;
    gcnt_d   = gcnt_q;
    snap_d   = snap_q;
    shadow_d = shadow_q;
    req_d    = bus_req;
    rwo_d    = bus_rw;
    addr_d   = bus_addr;
    wdata_d  = bus_wdata;
    sel_d    = field_sel;
    busy_d   = busy;
    done_d   = 1'b0;
    rd_d     = rd_fields;
    launch   = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        req_d  = 1'b0;
        rwo_d  = 1'b0;
        sel_d  = '0;
        if (go_q) begin
          go_d   = 1'b0;
          launch = 1'b1;
        end else if (start_any) begin
          go_d   = 1'b1;
          snap_d = wr_fields;
          priority case (1'b1)
            start_wr_time: begin
              idx_d  = 4'd0;
              last_d = 4'd5;
              rw_d   = 1'b1;
            end
            start_wr_timer: begin
              idx_d  = 4'd6;
              last_d = 4'd8;
              rw_d   = 1'b1;
            end
            default: begin
              idx_d  = 4'd0;
              last_d = 4'd8;
              rw_d   = 1'b0;
            end
          endcase
        end
      end
      REQ: begin
        if (bus_done) begin
          if (!rw_q)
            shadow_d[{idx_q, 3'b000} +: 8] = bus_rdata;
          state_d = GAP;
          req_d   = 1'b0;
          gcnt_d  = '0;
        end else if (tmo) begin
          // abort: shadow bytes are dropped, rd_fields keeps old data
          state_d = FINISH;
          req_d   = 1'b0;
          sel_d   = '0;
          done_d  = 1'b1;
        end
      end
      GAP: begin
        if (gcnt_q == 4'(GAP_CYCLES - 1)) begin
          if (idx_q == last_q) begin
            state_d = FINISH;
            done_d  = 1'b1;
            sel_d   = '0;
            if (!rw_q)
              rd_d = shadow_q;
          end else begin
            idx_d  = idx_q + 4'd1;
            launch = 1'b1;
          end
        end else begin
          gcnt_d = gcnt_q + 4'd1;
        end
      end
      FINISH: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        rwo_d   = 1'b0;
        sel_d   = '0;
      end
      default: state_d = IDLE;
    endcase
    if (launch) begin
      state_d = REQ;
      req_d   = 1'b1;
      busy_d  = 1'b1;
      rwo_d   = rw_q;
      addr_d  = addr_of(idx_d);
      wdata_d = rw_q ? byte_of(snap_q, idx_d) : 8'h00;
      sel_d   = 9'd1 << idx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      go_q      <= 1'b0;
      rw_q      <= 1'b0;
      idx_q     <= '0;
      last_q    <= '0;
      gcnt_q    <= '0;
      snap_q    <= '0;
      shadow_q  <= '0;
      bus_req   <= 1'b0;
      bus_rw    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      field_sel <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_fields <= '0;
    end else begin
      state_q   <= state_d;
      go_q      <= go_d;
      rw_q      <= rw_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      gcnt_q    <= gcnt_d;
      snap_q    <= snap_d;
      shadow_q  <= shadow_d;
      bus_req   <= req_d;
      bus_rw    <= rwo_d;
      bus_addr  <= addr_d;
      bus_wdata <= wdata_d;
      field_sel <= sel_d;
      busy      <= busy_d;
      done      <= done_d;
      rd_fields <= rd_d;
    end
  end

`ifdef RTC_SEQ_TIMEOUT_EN
  localparam int TW =
    (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [TW-1:0] tcnt_q;

  assign tmo = (state_q == REQ) && !bus_done &&
               (tcnt_q == TW'(TIMEOUT_CYCLES - 1));

  // counter is zero on every REQ entry since it clears outside REQ
  always_ff @(posedge clk) begin
    if (!reset) begin
      tcnt_q <= '0;
      err    <= 1'b0;
    end else begin
      tcnt_q <= (state_q == REQ) ? tcnt_q + TW'(1) : '0;
      err    <= tmo;
    end
  end
`else
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_rtc_transfer_sequencer.sv
// tb_rtc_transfer_sequencer: vector table, hand sequences and randomized
// transfers checked against a field-level reference model.
module tb_rtc_transfer_sequencer;

  localparam int TMO = 20;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start_wr_time = 1'b0;
  logic        start_wr_timer = 1'b0;
  logic        start_rd_all = 1'b0;
  logic [71:0] wr_fields = '0;
  logic        bus_req;
  logic        bus_rw;
  logic [7:0]  bus_addr;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata = '0;
  logic        bus_done = 1'b0;
  logic [71:0] rd_fields;
  logic [8:0]  field_sel;
  logic        busy;
  logic        done;
  logic        err;

  always #5 clk = ~clk;

  rtc_transfer_sequencer #(
    .TIMEOUT_CYCLES(TMO),
    .GAP_CYCLES(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start_wr_time(start_wr_time),
    .start_wr_timer(start_wr_timer),
    .start_rd_all(start_rd_all),
    .wr_fields(wr_fields),
    .bus_req(bus_req),
    .bus_rw(bus_rw),
    .bus_addr(bus_addr),
    .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata),
    .bus_done(bus_done),
    .rd_fields(rd_fields),
    .field_sel(field_sel),
    .busy(busy),
    .done(done),
    .err(err)
  );

  int tests = 0;
  int fails = 0;
  bit rnd_data = 1'b0;
  logic [71:0] exp_rd = '0;
  logic [7:0] amap [9] = '{8'h26, 8'h25, 8'h24, 8'h23, 8'h22,
                           8'h21, 8'h43, 8'h42, 8'h41};

  typedef struct {
    logic [2:0] st;
    int         dly;
    int         pulse;
    int         first;
    int         n;
    bit         rw;
    int         cyc;
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string name, input logic [71:0] act,
                       input logic [71:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // st = {wr_time, wr_timer, rd_all}; dly < 0 means the bus never answers
  task automatic run_seq(input logic [2:0] st, input int dly, input int pulse,
                         input int first, input int n, input bit rw,
                         input int exp_cyc, input bit exp_err);
    logic [71:0] snap;
    logic [71:0] pend;
    logic [7:0]  a0, d0, rdat;
    logic        r0;
    int k, w, done_cyc, done_cnt;
    bit unstable, issued;
    snap = wr_fields;
    pend = exp_rd;
    a0 = '0; d0 = '0; r0 = 1'b0;
    {start_wr_time, start_wr_timer, start_rd_all} = st;
    @(posedge clk); #1;
    {start_wr_time, start_wr_timer, start_rd_all} = 3'b000;
    k = 0; w = 0; done_cyc = 0; done_cnt = 0;
    unstable = 1'b0; issued = 1'b0;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(posedge clk); #1;
      bus_done = 1'b0;
      if (cyc == 3)
        wr_fields = {8'($urandom), $urandom, $urandom};
      {start_wr_time, start_wr_timer, start_rd_all} =
        (pulse != 0 && cyc == pulse) ? 3'b111 : 3'b000;
      if (issued && bus_req) unstable = 1'b1;
      issued = 1'b0;
      if (bus_req) begin
        if (w == 0) begin
          a0 = bus_addr; d0 = bus_wdata; r0 = bus_rw;
        end else if (bus_addr !== a0 || bus_wdata !== d0 || bus_rw !== r0) begin
          unstable = 1'b1;
        end
        if (w == dly) begin
          if (k < n) begin
            check("tx_addr", bus_addr, amap[first+k]);
            check("tx_rw", bus_rw, rw);
            check("tx_sel", field_sel, 9'd1 << (first + k));
            if (rw) check("tx_wdata", bus_wdata, snap[8*(first+k) +: 8]);
            rdat = rnd_data ? 8'($urandom) : 8'(8'h10 + first + k);
            pend[8*(first+k) +: 8] = rdat;
          end else begin
            check("tx_extra", k, n);
            rdat = 8'h00;
          end
          bus_rdata = rdat;
          bus_done = 1'b1;
          issued = 1'b1;
          k++;
          w = 0;
        end else begin
          w++;
        end
      end else begin
        w = 0;
      end
      if (done) begin
        done_cnt++;
        if (done_cnt == 1) begin
          done_cyc = cyc;
          check("done_cyc", done_cyc, exp_cyc);
          check("err", err, exp_err);
          check("busy_at_done", busy, 1'b1);
          check("tx_count", k, exp_err ? 0 : n);
          if (!rw && !exp_err) exp_rd = pend;
          check("rd_fields", rd_fields, exp_rd);
        end
      end
      if (done_cnt > 0 && cyc >= done_cyc + 4) break;
    end
    bus_done = 1'b0;
    check("done_count", done_cnt, 1);
    check("bus_stable", unstable, 1'b0);
    check("idle_outs", {busy, bus_req, bus_rw, field_sel, err}, '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [2:0] st;
    int first, n, dly, pulse, dcnt;
    bit rw, seen;

    tbl[0] = '{3'b001, 0, 0, 0, 9, 1'b0, 19};
    tbl[1] = '{3'b100, 0, 0, 0, 6, 1'b1, 13};
    tbl[2] = '{3'b111, 0, 4, 0, 6, 1'b1, 13};
    tbl[3] = '{3'b010, 5, 0, 6, 3, 1'b1, 22};
    tbl[4] = '{3'b010, 0, 0, 6, 3, 1'b1, 7};
    tbl[5] = '{3'b011, 1, 0, 6, 3, 1'b1, 10};
    tbl[6] = '{3'b001, 2, 5, 0, 9, 1'b0, 37};

    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_outs",
          {bus_req, bus_rw, bus_addr, bus_wdata, field_sel, busy, done, err}, '0);
    check("rst_rd", rd_fields, '0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("post_rst_outs",
          {bus_req, bus_rw, bus_addr, bus_wdata, field_sel, busy, done, err}, '0);

    for (int i = 0; i < 7; i++) begin
      wr_fields = {8'h99, 8'h88, 8'h77, 8'h58, 8'h59,
                   8'h23, 8'h31, 8'h12, 8'h24};
      run_seq(tbl[i].st, tbl[i].dly, tbl[i].pulse, tbl[i].first,
              tbl[i].n, tbl[i].rw, tbl[i].cyc, 1'b0);
    end
    check("rd_const", rd_fields, 72'h18_1716_1514_1312_1110);

    // reset while field 3 of a read is on the bus
    start_rd_all = 1'b1;
    @(posedge clk); #1;
    start_rd_all = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(posedge clk); #1;
      bus_done = 1'b0;
      if (bus_req && field_sel == 9'h008) begin
        seen = 1'b1;
      end else if (bus_req) begin
        bus_rdata = 8'hA5;
        bus_done = 1'b1;
      end
    end
    check("reach_field3", seen, 1'b1);
    reset = 1'b0;
    @(posedge clk); #1;
    check("midrst_req", bus_req, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_rd", rd_fields, '0);
    check("midrst_sel", field_sel, '0);
    reset = 1'b1;
    exp_rd = '0;
    dcnt = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    check("midrst_no_done", dcnt, 0);

    rnd_data = 1'b1;
    for (int i = 0; i < 30; i++) begin
      st = 3'($urandom_range(1, 7));
      dly = $urandom_range(0, 3);
      wr_fields = {8'($urandom), $urandom, $urandom};
      if (st[2]) begin
        first = 0; n = 6; rw = 1'b1;
      end else if (st[1]) begin
        first = 6; n = 3; rw = 1'b1;
      end else begin
        first = 0; n = 9; rw = 1'b0;
      end
      pulse = ($urandom_range(0, 1) == 1) ? $urandom_range(2, 2 * n) : 0;
      run_seq(st, dly, pulse, first, n, rw, 1 + n * (dly + 2), 1'b0);
    end

`ifdef RTC_SEQ_TIMEOUT_EN
    run_seq(3'b001, -1, 0, 0, 9, 1'b0, 1 + TMO, 1'b1);
    run_seq(3'b010, -1, 0, 6, 3, 1'b1, 1 + TMO, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
